iterative_alu: RTL and testbench

//   Execute unit directly downstream of the ALU decoder. Consumes its 4-bit

---
 rtl/iterative_alu_if.sv | 24 ++
 rtl/iterative_alu.sv | 140 ++++++++++++++
 tb/tb_iterative_alu.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/iterative_alu_if.sv
// Handshake and operand bundle between the control unit and the iterative ALU.
// The control unit drives the master side; the ALU is the slave.
interface iterative_alu_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [3:0]      aluControl;
  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] srcB;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            branchTaken;

  modport master (
    output start, aluControl, srcA, srcB,
    input  busy, done, result, branchTaken
  );

  modport slave (
    input  start, aluControl, srcA, srcB,
    output busy, done, result, branchTaken
  );
endinterface

// File: rtl/iterative_alu.sv
// Execute unit: single-cycle arithmetic/logic/compare ops and
// bit-serial shifts (one bit per cycle) behind a start/busy/done handshake.
module iterative_alu #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input logic           clk,
  input logic           rst_n,
  iterative_alu_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state, next_state;

  logic [XLEN-1:0]    shreg;
  logic [SHAMT_W-1:0] cnt;
  logic [3:0]         op;
  logic [XLEN-1:0]    result_q;
  logic               branch_q;

  logic [XLEN-1:0]    alu_res;
  logic               cond;
  logic               is_cmp;
  logic               is_shift;
  logic               accept;
  logic               lt;
  logic               ltu;
  logic [XLEN-1:0]    shifted;
  logic [SHAMT_W-1:0] cnt_in;

  assign cnt_in   = bus.srcB[SHAMT_W-1:0];
  assign accept   = bus.start && (state != SHIFT);
  assign is_shift = (bus.aluControl == 4'h2) ||
                    (bus.aluControl == 4'h6) ||
                    (bus.aluControl == 4'h7);
  assign lt       = $signed(bus.srcA) < $signed(bus.srcB);
  assign ltu      = bus.srcA < bus.srcB;

  always_comb begin
    cond    = 1'b0;
    is_cmp  = 1'b0;
    alu_res = bus.srcA + bus.srcB;
    case (bus.aluControl)
      4'h1: alu_res = bus.srcA - bus.srcB;
      4'h3: begin is_cmp = 1'b1; cond = lt; end
      4'h4: begin is_cmp = 1'b1; cond = ltu; end
      4'h5: alu_res = bus.srcA ^ bus.srcB;
      4'h8: alu_res = bus.srcA | bus.srcB;
      4'h9: alu_res = bus.srcA & bus.srcB;
      4'ha: begin is_cmp = 1'b1; cond = bus.srcA == bus.srcB; end
      4'hb: begin is_cmp = 1'b1; cond = bus.srcA != bus.srcB; end
      4'hc: begin is_cmp = 1'b1; cond = !lt; end
      4'hd: begin is_cmp = 1'b1; cond = !ltu; end
      default: alu_res = bus.srcA + bus.srcB;
    endcase
    if (is_cmp) begin
      alu_res = {{(XLEN-1){1'b0}}, cond};
    end
  end

  always_comb begin
    case (op)
      4'h2:    shifted = {shreg[XLEN-2:0], 1'b0};
      4'h6:    shifted = {shreg[XLEN-1], shreg[XLEN-1:1]};
      default: shifted = {1'b0, shreg[XLEN-1:1]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE, DONE: begin
        if (!bus.start)
          next_state = IDLE;
        else if (is_shift && (cnt_in != '0))
          next_state = SHIFT;
        else
          next_state = DONE;
      end
      SHIFT: begin
        if (cnt == SHAMT_W'(1))
          next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == SHIFT);
    bus.done = (state == DONE);
  end

  // A zero shift count bypasses the SHIFT state and returns srcA directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      cnt      <= '0;
      op       <= '0;
      result_q <= '0;
      branch_q <= 1'b0;
    end else if (accept) begin
      if (is_shift) begin
        shreg <= bus.srcA;
        cnt   <= cnt_in;
        op    <= bus.aluControl;
        if (cnt_in == '0) begin
          result_q <= bus.srcA;
          branch_q <= 1'b0;
        end
      end else begin
        result_q <= alu_res;
        branch_q <= is_cmp & cond;
      end
    end else if (state == SHIFT) begin
      shreg <= shifted;
      cnt   <= cnt - SHAMT_W'(1);
      if (cnt == SHAMT_W'(1)) begin
        result_q <= shifted;
        branch_q <= 1'b0;
      end
    end
  end

  assign bus.result      = result_q;
  assign bus.branchTaken = branch_q;

endmodule

// File: tb/tb_iterative_alu.sv
// Directed-vector bench for iterative_alu: table of ops with
// hand-computed results plus shift abort / ignore-start sequences.
module tb_iterative_alu;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  iterative_alu_if #(.XLEN(32)) bus ();

  iterative_alu #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        br;
    int          lat;
    int          bsy;
  } vec_t;

  vec_t vt[20];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run(input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, output int lat, output int bsy);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.aluControl = op;
    bus.srcA       = a;
    bus.srcB       = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.srcA  = ~a;
    bus.srcB  = ~b;
    lat = 1;
    bsy = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) bsy++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int bsy;
    int dn;
    n_cmp = 0;
    n_bad = 0;

    vt[0]  = '{"add",      4'h0, 32'd5,        32'd7,  32'd12,       1'b0, 1,  0};
    vt[1]  = '{"sub",      4'h1, 32'd3,        32'd5,  32'hFFFFFFFE, 1'b0, 1,  0};
    vt[2]  = '{"sltu",     4'h4, 32'hFFFFFFFF, 32'd1,  32'd0,        1'b0, 1,  0};
    vt[3]  = '{"sra4",     4'h6, 32'h80000000, 32'd4,  32'hF8000000, 1'b0, 5,  4};
    vt[4]  = '{"srl4",     4'h7, 32'h80000000, 32'd4,  32'h08000000, 1'b0, 5,  4};
    vt[5]  = '{"sll0",     4'h2, 32'h1,        32'd0,  32'h1,        1'b0, 1,  0};
    vt[6]  = '{"sll31",    4'h2, 32'h1,        32'd31, 32'h80000000, 1'b0, 32, 31};
    vt[7]  = '{"blt",      4'h3, 32'hFFFFFFFF, 32'd1,  32'd1,        1'b1, 1,  0};
    vt[8]  = '{"bgeu",     4'hd, 32'hFFFFFFFF, 32'd1,  32'd1,        1'b1, 1,  0};
    vt[9]  = '{"beq",      4'ha, 32'd7,        32'd7,  32'd1,        1'b1, 1,  0};
    vt[10] = '{"bne",      4'hb, 32'd7,        32'd7,  32'd0,        1'b0, 1,  0};
    vt[11] = '{"xor",      4'h5, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1'b0, 1, 0};
    vt[12] = '{"or",       4'h8, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0, 1, 0};
    vt[13] = '{"and",      4'h9, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1, 0};
    vt[14] = '{"slt",      4'h3, 32'd1,        32'hFFFFFFFF, 32'd0,  1'b0, 1,  0};
    vt[15] = '{"bge",      4'hc, 32'hFFFFFFFF, 32'd1,  32'd0,        1'b0, 1,  0};
    vt[16] = '{"op_e_add", 4'he, 32'd1,        32'd2,  32'd3,        1'b0, 1,  0};
    vt[17] = '{"add_wrap", 4'h0, 32'hFFFFFFFF, 32'd1,  32'd0,        1'b0, 1,  0};
    vt[18] = '{"srl_hiB",  4'h7, 32'h000000F0, 32'h24, 32'h0000000F, 1'b0, 5,  4};
    vt[19] = '{"sra_pos",  4'h6, 32'h40000000, 32'd2,  32'h10000000, 1'b0, 3,  2};

    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.aluControl = 4'h0;
    bus.srcA       = '0;
    bus.srcB       = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",   32'(bus.busy),        32'd0);
    chk("rst_done",   32'(bus.done),        32'd0);
    chk("rst_result", bus.result,           32'd0);
    chk("rst_branch", 32'(bus.branchTaken), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      run(vt[i].op, vt[i].a, vt[i].b, lat, bsy);
      chk({vt[i].name, "_lat"},    32'(lat),             32'(vt[i].lat));
      chk({vt[i].name, "_busy"},   32'(bsy),             32'(vt[i].bsy));
      chk({vt[i].name, "_result"}, bus.result,           vt[i].res);
      chk({vt[i].name, "_branch"}, 32'(bus.branchTaken), 32'(vt[i].br));
    end

    // done is a single-cycle pulse and result is held afterwards
    @(posedge clk);
    #1;
    chk("pulse_done",  32'(bus.done), 32'd0);
    chk("pulse_busy",  32'(bus.busy), 32'd0);
    chk("hold_result", bus.result,    32'h10000000);

    // start pulses during an 8-cycle shift are ignored
    @(negedge clk);
    bus.start      = 1'b1;
    bus.aluControl = 4'h7;
    bus.srcA       = 32'h00000100;
    bus.srcB       = 32'd8;
    dn = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) dn++;
      if (c >= 1 && c <= 5) begin
        bus.start      = 1'b1;
        bus.aluControl = 4'h0;
        bus.srcA       = 32'd100 + 32'(c);
        bus.srcB       = 32'd1;
      end else begin
        bus.start = 1'b0;
      end
    end
    chk("ign_done_cnt", 32'(dn),   32'd1);
    chk("ign_result",   bus.result, 32'h00000001);

    // reset mid-shift aborts the op immediately
    @(negedge clk);
    bus.start      = 1'b1;
    bus.aluControl = 4'h2;
    bus.srcA       = 32'h1;
    bus.srcB       = 32'd20;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy",   32'(bus.busy),        32'd0);
    chk("abort_done",   32'(bus.done),        32'd0);
    chk("abort_result", bus.result,           32'd0);
    chk("abort_branch", 32'(bus.branchTaken), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) dn++;
    end
    chk("abort_quiet", 32'(dn), 32'd0);

    run(4'h0, 32'd5, 32'd7, lat, bsy);
    chk("recover_lat",    32'(lat),   32'd1);
    chk("recover_result", bus.result, 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
